// File: rtl/boundary_sqrt_scheduler_pkg.sv
// Shared constants, FSM encodings and the round-robin pick for the boundary sqrt scheduler.
package boundary_sqrt_scheduler_pkg;

  localparam int WIDTH_DEF = 18;
  localparam int NREQ      = 3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_SQRT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Nominal omega operands of the boundary detectors
  localparam int SR3       = 514;
  localparam int BETA_LOW  = 410;
  localparam int BETA_HIGH = 664;

  // First set request at or after ptr, scanning cyclically over three requesters.
  // Scans far-to-near so the nearest hit is the one left standing.
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    int s;
    rr_pick = ptr;
    for (int k = 2; k >= 0; k--) begin
      s = int'(ptr) + k;
      if (s >= 3) s = s - 3;
      idx = 2'(s);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/boundary_sqrt_scheduler_if.sv
// Requester-side bundle: level requests, per-requester operands and the shared result bus.
interface boundary_sqrt_scheduler_if
  import boundary_sqrt_scheduler_pkg::*;
#(parameter int WIDTH = WIDTH_DEF);
  logic        [2:0]       req;
  logic signed [WIDTH-1:0] omega_lo_0, omega_lo_1, omega_lo_2;
  logic signed [WIDTH-1:0] omega_hi_0, omega_hi_1, omega_hi_2;
  logic        [2:0]       ack;
  logic signed [WIDTH-1:0] sqrt_root;
  logic                    invalid;
  logic                    busy;
  logic        [1:0]       grant_id;

  modport master (
    output req, omega_lo_0, omega_lo_1, omega_lo_2, omega_hi_0, omega_hi_1, omega_hi_2,
    input  ack, sqrt_root, invalid, busy, grant_id
  );
  modport slave (
    input  req, omega_lo_0, omega_lo_1, omega_lo_2, omega_hi_0, omega_hi_1, omega_hi_2,
    output ack, sqrt_root, invalid, busy, grant_id
  );
endinterface

// File: rtl/boundary_sqrt_scheduler_isqrt_seq.sv
// Bit-serial restoring integer square root: one root bit per enabled edge, W steps after start.
module isqrt_seq #(
  parameter int W = 18
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clk_en,
  input  logic           start,
  input  logic [2*W-1:0] radicand,
  output logic           done,
  output logic [W-1:0]   root
);
  localparam int CW = $clog2(W);

  logic [2*W-1:0] rad;
  logic [W+2:0]   rem, rem_sh, trial, diff;
  logic [W-1:0]   root_q;
  logic [CW-1:0]  cnt;
  logic           run;
  logic           ge;

  // Bring down the next two radicand bits and try subtracting 4*root+1
  assign rem_sh = (rem << 2) | (W+3)'(rad[2*W-1 -: 2]);
  assign trial  = {1'b0, root_q, 2'b01};
  assign ge     = rem_sh >= trial;
  assign diff   = rem_sh - trial;
  assign done   = run && (cnt == '0);
  assign root   = root_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rad    <= '0;
      rem    <= '0;
      root_q <= '0;
      cnt    <= '0;
      run    <= 1'b0;
    end else if (clk_en) begin
      if (start) begin
        rad    <= radicand;
        rem    <= '0;
        root_q <= '0;
        cnt    <= CW'(W-1);
        run    <= 1'b1;
      end else if (run) begin
        rad    <= rad << 2;
        rem    <= ge ? diff : rem_sh;
        root_q <= {root_q[W-2:0], ge};
        if (cnt == '0) run <= 1'b0;
        else           cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

// File: rtl/boundary_sqrt_scheduler.sv
// Round-robin front end sharing one sequential sqrt among the three boundary detectors.
module boundary_sqrt_scheduler
  import boundary_sqrt_scheduler_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clk_en,
  boundary_sqrt_scheduler_if.slave  bus
);
  logic        [1:0]       state, ptr, gid, pick;
  logic signed [WIDTH-1:0] lo_r, hi_r, lo_sel, hi_sel;
  logic [2*WIDTH-1:0]      radicand;
  logic                    op_bad, inv_r, inv_q, sq_start, sq_done;
  logic [2:0]              ack_q;
  logic [WIDTH-1:0]        root_q, sq_root;

  always_comb pick = rr_pick(bus.req, ptr);

  always_comb begin
    lo_sel = '0;
    hi_sel = '0;
    case (pick)
      2'd0:    begin lo_sel = bus.omega_lo_0; hi_sel = bus.omega_hi_0; end
      2'd1:    begin lo_sel = bus.omega_lo_1; hi_sel = bus.omega_hi_1; end
      2'd2:    begin lo_sel = bus.omega_lo_2; hi_sel = bus.omega_hi_2; end
      default: ;
    endcase
  end

  // Non-positive operand forces a zero radicand, so the root comes out 0
  assign op_bad   = lo_r[WIDTH-1] | (lo_r == '0) | hi_r[WIDTH-1] | (hi_r == '0);
  assign radicand = op_bad ? '0
                  : (2*WIDTH)'($unsigned(lo_r)) * (2*WIDTH)'($unsigned(hi_r));
  assign sq_start = (state == S_MUL);

  isqrt_seq #(.W(WIDTH)) u_isqrt (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .start    (sq_start),
    .radicand (radicand),
    .done     (sq_done),
    .root     (sq_root)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      ptr    <= '0;
      gid    <= '0;
      lo_r   <= '0;
      hi_r   <= '0;
      inv_r  <= 1'b0;
      inv_q  <= 1'b0;
      ack_q  <= '0;
      root_q <= '0;
    end else if (clk_en) begin
      case (state)
        S_IDLE: if (|bus.req) begin
          gid   <= pick;
          lo_r  <= lo_sel;
          hi_r  <= hi_sel;
          ptr   <= (pick == 2'd2) ? 2'd0 : pick + 2'd1;
          state <= S_MUL;
        end
        S_MUL: begin
          inv_r <= op_bad;
          state <= S_SQRT;
        end
        S_SQRT: if (sq_done) state <= S_DONE;
        // DONE spans two edges: publish + ack, then drop ack and go idle
        S_DONE: if (ack_q == '0) begin
          ack_q  <= 3'b001 << gid;
          root_q <= sq_root;
          inv_q  <= inv_r;
        end else begin
          ack_q <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ack       = ack_q;
  assign bus.sqrt_root = root_q;
  assign bus.invalid   = inv_q;
  assign bus.busy      = (state != S_IDLE);
  assign bus.grant_id  = gid;
endmodule

// File: tb/tb_boundary_sqrt_scheduler.sv
// Directed self-checking bench for boundary_sqrt_scheduler.
module tb_boundary_sqrt_scheduler;
  logic clk = 1'b0, rst = 1'b1, clk_en = 1'b1;
  int   en_div = 1, ph = 0;
  int   checks = 0, failures = 0;

  boundary_sqrt_scheduler_if #(.WIDTH(18)) bus();

  boundary_sqrt_scheduler dut (.clk(clk), .rst(rst), .clk_en(clk_en), .bus(bus));

  always #5 clk = ~clk;

  // clk_en pattern: high once every en_div clocks, settles 2ns after the edge
  always @(posedge clk) begin
    #2;
    ph = (ph + 1 >= en_div) ? 0 : ph + 1;
    clk_en = (ph == 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic set_ops(input int idx, input logic signed [17:0] lo, input logic signed [17:0] hi);
    case (idx)
      0: begin bus.omega_lo_0 = lo; bus.omega_hi_0 = hi; end
      1: begin bus.omega_lo_1 = lo; bus.omega_hi_1 = hi; end
      default: begin bus.omega_lo_2 = lo; bus.omega_hi_2 = hi; end
    endcase
  endtask

  // Single request: lat = clocks from grant edge to the edge that raises ack
  task automatic do_req(input int idx, input logic signed [17:0] lo, input logic signed [17:0] hi,
                        output int lat, output logic [2:0] ack_o, output logic [17:0] root_o,
                        output logic inv_o, output int ack_len);
    @(negedge clk);
    while (!clk_en) @(negedge clk);
    set_ops(idx, lo, hi);
    bus.req[idx] = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (bus.ack == 3'b000 && lat < 2000) begin @(posedge clk); #1; lat++; end
    ack_o = bus.ack; root_o = bus.sqrt_root; inv_o = bus.invalid;
    @(negedge clk);
    bus.req[idx] = 1'b0;
    ack_len = (ack_o != 3'b000) ? 1 : 0;
    while (bus.ack != 3'b000 && ack_len < 100) begin
      @(posedge clk); #1;
      if (bus.ack != 3'b000) ack_len++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = 3'b000;
    for (int i = 0; i < 3; i++) set_ops(i, 18'sd0, 18'sd0);
    repeat (3) @(negedge clk);
    checks++; if (bus.ack !== 3'b000) begin failures++; $display("FAIL reset_ack got=%b exp=000", bus.ack); end
    checks++; if (bus.sqrt_root !== 18'd0) begin failures++; $display("FAIL reset_root got=%0d exp=0", bus.sqrt_root); end
    checks++; if (bus.invalid !== 1'b0) begin failures++; $display("FAIL reset_invalid got=%b exp=0", bus.invalid); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant got=%0d exp=0", bus.grant_id); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat, alen; logic [2:0] a; logic [17:0] r; logic inv;
    do_req(0, 18'sd410, 18'sd664, lat, a, r, inv, alen);
    checks++; if (lat !== 20) begin failures++; $display("FAIL basic_latency got=%0d exp=20", lat); end
    checks++; if (a !== 3'b001) begin failures++; $display("FAIL basic_ack got=%b exp=001", a); end
    checks++; if (r !== 18'd521) begin failures++; $display("FAIL basic_root got=%0d exp=521", r); end
    checks++; if (inv !== 1'b0) begin failures++; $display("FAIL basic_invalid got=%b exp=0", inv); end
    checks++; if (alen !== 1) begin failures++; $display("FAIL basic_ack_len got=%0d exp=1", alen); end
  endtask

  task automatic test_square();
    int lat, alen; logic [2:0] a; logic [17:0] r; logic inv;
    do_req(2, 18'sd514, 18'sd514, lat, a, r, inv, alen);
    checks++; if (r !== 18'd514) begin failures++; $display("FAIL square_root got=%0d exp=514", r); end
    checks++; if (a !== 3'b100) begin failures++; $display("FAIL square_ack got=%b exp=100", a); end
    do_req(1, 18'sd131071, 18'sd131071, lat, a, r, inv, alen);
    checks++; if (r !== 18'd131071) begin failures++; $display("FAIL max_root got=%0d exp=131071", r); end
    checks++; if (a !== 3'b010) begin failures++; $display("FAIL max_ack got=%b exp=010", a); end
    checks++; if (inv !== 1'b0) begin failures++; $display("FAIL max_invalid got=%b exp=0", inv); end
  endtask

  task automatic test_invalid();
    int lat, alen; logic [2:0] a; logic [17:0] r; logic inv;
    do_req(0, -18'sd5, 18'sd664, lat, a, r, inv, alen);
    checks++; if (r !== 18'd0) begin failures++; $display("FAIL neg_root got=%0d exp=0", r); end
    checks++; if (inv !== 1'b1) begin failures++; $display("FAIL neg_invalid got=%b exp=1", inv); end
    checks++; if (a !== 3'b001) begin failures++; $display("FAIL neg_ack got=%b exp=001", a); end
    do_req(2, 18'sd7, 18'sd0, lat, a, r, inv, alen);
    checks++; if (inv !== 1'b1 || r !== 18'd0) begin failures++; $display("FAIL zero_op got inv=%b root=%0d exp inv=1 root=0", inv, r); end
    do_req(1, 18'sd410, 18'sd664, lat, a, r, inv, alen);
    checks++; if (inv !== 1'b0) begin failures++; $display("FAIL clear_invalid got=%b exp=0", inv); end
    checks++; if (r !== 18'd521) begin failures++; $display("FAIL clear_root got=%0d exp=521", r); end
  endtask

  task automatic test_clk_en();
    int lat, alen; logic [2:0] a; logic [17:0] r; logic inv;
    en_div = 4;
    repeat (8) @(negedge clk);
    do_req(2, 18'sd410, 18'sd664, lat, a, r, inv, alen);
    checks++; if (lat !== 80) begin failures++; $display("FAIL slow_latency got=%0d exp=80", lat); end
    checks++; if (alen !== 4) begin failures++; $display("FAIL slow_ack_len got=%0d exp=4", alen); end
    checks++; if (r !== 18'd521 || a !== 3'b100) begin failures++; $display("FAIL slow_result got root=%0d ack=%b exp root=521 ack=100", r, a); end
    en_div = 1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [2:0]  exp_ack  [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [17:0] exp_root [4] = '{18'd100, 18'd200, 18'd300, 18'd100};
    logic [1:0]  exp_next [4] = '{2'd1, 2'd2, 2'd0, 2'd1};
    int t; int who; logic seen;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    set_ops(0, 18'sd100, 18'sd100);
    set_ops(1, 18'sd200, 18'sd200);
    set_ops(2, 18'sd300, 18'sd300);
    bus.req = 3'b111;
    for (int s = 0; s < 4; s++) begin
      who = s % 3;
      t = 0;
      @(posedge clk); #1;
      while (bus.ack == 3'b000 && t < 100) begin @(posedge clk); #1; t++; end
      checks++; if (bus.ack !== exp_ack[s]) begin failures++; $display("FAIL rr_ack%0d got=%b exp=%b", s, bus.ack, exp_ack[s]); end
      checks++; if (bus.sqrt_root !== exp_root[s]) begin failures++; $display("FAIL rr_root%0d got=%0d exp=%0d", s, bus.sqrt_root, exp_root[s]); end
      @(negedge clk); bus.req[who] = 1'b0;
      @(posedge clk); #1;
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rr_gap%0d busy got=%b exp=0", s, bus.busy); end
      @(negedge clk); bus.req[who] = 1'b1;
      @(posedge clk); #1;
      checks++; if (bus.busy !== 1'b1 || bus.grant_id !== exp_next[s]) begin
        failures++; $display("FAIL rr_regrant%0d got busy=%b gid=%0d exp busy=1 gid=%0d", s, bus.busy, bus.grant_id, exp_next[s]);
      end
    end
    // Requester 1 is now in flight: dropping req and corrupting operands must not matter
    @(negedge clk);
    bus.req = 3'b000;
    bus.omega_lo_1 = -18'sd5;
    t = 0; seen = 1'b0;
    while (bus.busy && t < 100) begin
      @(posedge clk); #1; t++;
      if (bus.ack == 3'b010) seen = 1'b1;
    end
    checks++; if (seen !== 1'b1 || bus.sqrt_root !== 18'd200 || bus.invalid !== 1'b0) begin
      failures++; $display("FAIL late_change got seen=%b root=%0d inv=%b exp seen=1 root=200 inv=0", seen, bus.sqrt_root, bus.invalid);
    end
  endtask

  task automatic test_reset_mid();
    int t;
    @(negedge clk);
    set_ops(1, 18'sd410, 18'sd664);
    bus.req = 3'b010;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before got=%b exp=1", bus.busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.ack !== 3'b000) begin failures++; $display("FAIL mid_reset_ctrl got busy=%b ack=%b exp 0 000", bus.busy, bus.ack); end
    checks++; if (bus.sqrt_root !== 18'd0 || bus.invalid !== 1'b0 || bus.grant_id !== 2'd0) begin
      failures++; $display("FAIL mid_reset_out got root=%0d inv=%b gid=%0d exp 0 0 0", bus.sqrt_root, bus.invalid, bus.grant_id);
    end
    bus.req = 3'b000;
    @(negedge clk); rst = 1'b0;
    set_ops(0, 18'sd514, 18'sd514);
    set_ops(2, 18'sd300, 18'sd300);
    @(negedge clk); bus.req = 3'b111;
    @(posedge clk); #1;
    checks++; if (bus.grant_id !== 2'd0) begin failures++; $display("FAIL mid_ptr_reset got=%0d exp=0", bus.grant_id); end
    t = 0;
    while (bus.ack == 3'b000 && t < 100) begin @(posedge clk); #1; t++; end
    checks++; if (bus.ack !== 3'b001 || bus.sqrt_root !== 18'd514) begin
      failures++; $display("FAIL mid_after got ack=%b root=%0d exp ack=001 root=514", bus.ack, bus.sqrt_root);
    end
    @(negedge clk); bus.req = 3'b000;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    bus.req = 3'b000;
    test_reset();
    test_basic();
    test_square();
    test_invalid();
    test_clk_en();
    test_round_robin();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
